// File: rtl/sd_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_cache_arbiter
// Purpose  : Two-requester arbiter for the single SD block cache port, with an
//            access watchdog. Define SD_ARB_RR_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cache_arbiter #(
  parameter int TO_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_read,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ack,
  output logic        req0_err,
  input  logic        req1_read,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ack,
  output logic        req1_err,
  output logic        cache_read,
  output logic        cache_write,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  input  logic        cache_ready,
  output logic        grant,
  output logic        busy
);

  localparam logic [1:0]      c_S_IDLE   = 2'd0;
  localparam logic [1:0]      c_S_ISSUE  = 2'd1;
  localparam logic [1:0]      c_S_DONE   = 2'd2;
  // Count value one below all-ones: the increment out of it is the timeout
  localparam logic [TO_W-1:0] c_CNT_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] c_CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            r_grant;
  logic            r_op_read;
  logic            r_op_write;
  logic            r_timeout;
  logic [TO_W-1:0] r_cnt;
  logic [31:0]     r_cache_addr;
  logic [31:0]     r_cache_wdata;

  logic w_req0;
  logic w_req1;
  logic w_any;
  logic w_winner;
  logic w_sel_read;
  logic w_sel_write;

  assign w_req0 = req0_read | req0_write;
  assign w_req1 = req1_read | req1_write;
  assign w_any  = w_req0 | w_req1;

`ifdef SD_ARB_RR_EN
  // r_rr_ptr names the side that wins the next contention
  logic r_rr_ptr;
  assign w_winner = (w_req0 & w_req1) ? r_rr_ptr : ~w_req0;
`else
  assign w_winner = ~w_req0;
`endif

  assign w_sel_read  = w_winner ? req1_read  : req0_read;
  assign w_sel_write = (w_winner ? req1_write : req0_write) & ~w_sel_read;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE:  if (w_any) w_next_state = c_S_ISSUE;
      c_S_ISSUE: if (cache_ready || (r_cnt == c_CNT_LAST)) w_next_state = c_S_DONE;
      c_S_DONE:  w_next_state = c_S_IDLE;
      default:   w_next_state = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant       <= 1'b0;
      r_op_read     <= 1'b0;
      r_op_write    <= 1'b0;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
      r_cache_addr  <= '0;
      r_cache_wdata <= '0;
`ifdef SD_ARB_RR_EN
      r_rr_ptr      <= 1'b0;
`endif
    end else if ((r_state == c_S_IDLE) && w_any) begin
      r_grant       <= w_winner;
      r_op_read     <= w_sel_read;
      r_op_write    <= w_sel_write;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
      r_cache_addr  <= w_winner ? req1_addr  : req0_addr;
      r_cache_wdata <= w_winner ? req1_wdata : req0_wdata;
`ifdef SD_ARB_RR_EN
      r_rr_ptr      <= ~w_winner;
`endif
    end else if ((r_state == c_S_ISSUE) && !cache_ready) begin
      r_cnt <= r_cnt + c_CNT_ONE;
      if (r_cnt == c_CNT_LAST) r_timeout <= 1'b1;
    end
  end

  // Strobes fall combinationally in the ready cycle so the cache sees one access
  always_comb begin
    cache_read  = r_op_read  & (r_state == c_S_ISSUE) & ~cache_ready;
    cache_write = r_op_write & (r_state == c_S_ISSUE) & ~cache_ready;
    req0_ack    = (r_state == c_S_DONE) & ~r_grant;
    req1_ack    = (r_state == c_S_DONE) &  r_grant;
    req0_err    = req0_ack & r_timeout;
    req1_err    = req1_ack & r_timeout;
    busy        = (r_state != c_S_IDLE);
    grant       = r_grant;
    cache_addr  = r_cache_addr;
    cache_wdata = r_cache_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cache_arbiter
// Purpose  : Self-checking bench for sd_cache_arbiter (TO_W = 4), table vectors
//            plus randomized sessions against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cache_arbiter;

  localparam int c_TO_LIM = (1 << 4) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_read, req0_write, req1_read, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ack, req0_err, req1_ack, req1_err;
  logic        cache_read, cache_write, cache_ready;
  logic [31:0] cache_addr, cache_wdata;
  logic        grant, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int pref   = 0;
  logic obs_grant, obs_rd, obs_wr, obs_err;

  typedef struct {
    bit rd0; bit wr0; bit rd1; bit wr1;
    logic [31:0] ad0; logic [31:0] wd0; logic [31:0] ad1; logic [31:0] wd1;
    int dl0; int dl1;
    bit exp_grant; bit exp_rd; bit exp_wr; bit exp_err;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  sd_cache_arbiter #(.TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_read(req0_read), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_err(req0_err),
    .req1_read(req1_read), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_err(req1_err),
    .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_ready(cache_ready), .grant(grant), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic run_session(input vec_t v);
    bit pend[2];
    int dl[2];
    int win, n;
    bit rd_sel, wr_sel, done, to, first;
    logic [31:0] ea, ed;
    req0_read = v.rd0; req0_write = v.wr0; req0_addr = v.ad0; req0_wdata = v.wd0;
    req1_read = v.rd1; req1_write = v.wr1; req1_addr = v.ad1; req1_wdata = v.wd1;
    pend[0] = v.rd0 | v.wr0;
    pend[1] = v.rd1 | v.wr1;
    dl[0] = v.dl0;
    dl[1] = v.dl1;
    first = 1'b1;
    while (pend[0] || pend[1]) begin
`ifdef SD_ARB_RR_EN
      win  = (pend[0] && pend[1]) ? pref : (pend[0] ? 0 : 1);
      pref = 1 - win;
`else
      win = pend[0] ? 0 : 1;
`endif
      rd_sel = (win == 1) ? req1_read : req0_read;
      wr_sel = ((win == 1) ? req1_write : req0_write) & ~rd_sel;
      ea     = (win == 1) ? req1_addr  : req0_addr;
      ed     = (win == 1) ? req1_wdata : req0_wdata;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_acks", {req0_ack, req1_ack}, 0);
      n = 0; done = 1'b0; to = 1'b0;
      while (!done) begin
        @(posedge clk); #1;
        n++;
        cache_ready = (n == dl[win] + 1);
        // The waiting side may wander; the granted access must not follow it
        if (win == 1) begin req0_addr = $urandom; req0_wdata = $urandom; end
        else          begin req1_addr = $urandom; req1_wdata = $urandom; end
        @(negedge clk);
        chk("issue_cache_read",  cache_read,  rd_sel & ~cache_ready);
        chk("issue_cache_write", cache_write, wr_sel & ~cache_ready);
        chk("issue_cache_addr",  cache_addr,  ea);
        chk("issue_cache_wdata", cache_wdata, ed);
        chk("issue_grant", grant, win);
        chk("issue_busy", busy, 1);
        chk("issue_acks", {req0_ack, req1_ack}, 0);
        if (first) begin obs_rd |= cache_read; obs_wr |= cache_write; end
        if (cache_ready) done = 1'b1;
        else if (n == c_TO_LIM) begin done = 1'b1; to = 1'b1; end
      end
      @(posedge clk); #1;
      cache_ready = 1'b0;
      @(negedge clk);
      chk("done_ack_win",   (win == 1) ? req1_ack : req0_ack, 1);
      chk("done_ack_other", (win == 1) ? req0_ack : req1_ack, 0);
      chk("done_err_win",   (win == 1) ? req1_err : req0_err, to);
      chk("done_err_other", (win == 1) ? req0_err : req1_err, 0);
      chk("done_strobes", {cache_read, cache_write}, 0);
      chk("done_busy", busy, 1);
      if (first) begin
        obs_grant = grant;
        obs_err   = (win == 1) ? req1_err : req0_err;
        first     = 1'b0;
      end
      @(posedge clk); #1;
      if (win == 1) begin req1_read = 1'b0; req1_write = 1'b0; end
      else          begin req0_read = 1'b0; req0_write = 1'b0; end
      pend[win] = 1'b0;
    end
  endtask

  initial begin
    vec_t rv;
    // rd0 wr0 rd1 wr1  ad0  wd0  ad1  wd1  dl0 dl1  grant rd wr err
    vecs[0] = '{1,0,0,0, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 5, 0, 0,1,0,0};
    vecs[1] = '{1,0,0,1, 32'h0000_1000, 32'h0, 32'h0000_2000, 32'hA5A5_0001, 3, 2, 0,1,0,0};
    vecs[2] = '{0,0,0,1, 32'h0, 32'h0, 32'h0000_3000, 32'h1111_2222, 0, 99, 1,0,1,1};
    vecs[3] = '{0,0,1,1, 32'h0, 32'h0, 32'h0000_4000, 32'hDEAD_BEEF, 0, 2, 1,1,0,0};
    vecs[4] = '{1,0,1,0, 32'h0000_5000, 32'h0, 32'h0000_6000, 32'h0, 4, 1, 0,1,0,0};
    vecs[5] = '{0,1,1,0, 32'h0000_7000, 32'h0BAD_F00D, 32'h0000_8000, 32'h0, 0, 2, 0,0,0,0};
    vecs[6] = '{0,1,0,0, 32'h0000_9000, 32'h1234_5678, 32'h0, 32'h0, 2, 0, 0,0,1,0};

    rst = 1'b1; cache_ready = 1'b0;
    req0_read = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_read = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {cache_read, cache_write}, 0);
    chk("rst_acks_errs", {req0_ack, req1_ack, req0_err, req1_err}, 0);
    chk("rst_busy_grant", {busy, grant}, 0);
    chk("rst_cache_addr", cache_addr, 0);
    chk("rst_cache_wdata", cache_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      obs_grant = 0; obs_rd = 0; obs_wr = 0; obs_err = 0;
      run_session(vecs[i]);
`ifndef SD_ARB_RR_EN
      chk($sformatf("vec%0d_grant", i), obs_grant, vecs[i].exp_grant);
`endif
      chk($sformatf("vec%0d_read", i),  obs_rd,  vecs[i].exp_rd);
      chk($sformatf("vec%0d_write", i), obs_wr,  vecs[i].exp_wr);
      chk($sformatf("vec%0d_err", i),   obs_err, vecs[i].exp_err);
    end

    // cache_ready while idle must not start or complete anything
    cache_ready = 1'b1;
    @(negedge clk);
    chk("stray_ready_busy", busy, 0);
    @(posedge clk); #1;
    cache_ready = 1'b0;
    @(negedge clk);
    chk("stray_ready_after", {busy, req0_ack, req1_ack, cache_read, cache_write}, 0);
    @(posedge clk); #1;

    // Reset in the middle of a requester-1 access abandons it silently
    req1_write = 1'b1; req1_addr = 32'h0000_0055; req1_wdata = 32'h0000_00AA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_pre_write", cache_write, 1);
    chk("mid_pre_grant", grant, 1);
    @(posedge clk); #1;
    rst = 1'b1; req1_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_outs", {cache_read, cache_write, req0_ack, req1_ack, busy, grant}, 0);
    chk("mid_rst_addr", cache_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0; pref = 0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_ack", {req0_ack, req1_ack, busy}, 0);
    end
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      rv.rd0 = $urandom_range(0, 1); rv.wr0 = $urandom_range(0, 1);
      rv.rd1 = $urandom_range(0, 1); rv.wr1 = $urandom_range(0, 1);
      rv.ad0 = $urandom; rv.wd0 = $urandom; rv.ad1 = $urandom; rv.wd1 = $urandom;
      rv.dl0 = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 6);
      rv.dl1 = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 6);
      rv.exp_grant = 0; rv.exp_rd = 0; rv.exp_wr = 0; rv.exp_err = 0;
      run_session(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
